maxnet_act_update: RTL and testbench

//  Downstream stage of the PLU in the Maxnet datapath. Sequences one Maxnet iteration by issuing

---
 rtl/maxnet_act_update_if.sv | 34 +++
 rtl/maxnet_act_update.sv | 157 +++++++++++++++
 tb/tb_maxnet_act_update.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/maxnet_act_update_if.sv
// Maxnet activation-update bus: run control, PLU handshake and committed activations.
// The master side drives start/init/PLU results; the slave side is maxnet_act_update.
interface maxnet_act_update_if #(
  parameter int unsigned ITER_W = 8
);
  logic              start;
  logic [31:0]       init_a1;
  logic [31:0]       init_a2;
  logic [31:0]       init_a3;
  logic [31:0]       init_a4;
  logic [31:0]       plu_out;
  logic              plu_done;
  logic              plu_start;
  logic [1:0]        nrn_sel;
  logic [31:0]       a1;
  logic [31:0]       a2;
  logic [31:0]       a3;
  logic [31:0]       a4;
  logic              busy;
  logic              done;
  logic [1:0]        winner;
  logic              no_winner;
  logic [ITER_W-1:0] iter_cnt;

  modport master (
    output start, init_a1, init_a2, init_a3, init_a4, plu_out, plu_done,
    input  plu_start, nrn_sel, a1, a2, a3, a4, busy, done, winner, no_winner, iter_cnt
  );

  modport slave (
    input  start, init_a1, init_a2, init_a3, init_a4, plu_out, plu_done,
    output plu_start, nrn_sel, a1, a2, a3, a4, busy, done, winner, no_winner, iter_cnt
  );
endinterface

// File: rtl/maxnet_act_update.sv
// Maxnet iteration sequencer: issues four PLU evaluations, ReLUs results, commits them together.
// Optional ACT_CLAMP_EN macro clamps every loaded activation to at most 1.0 after ReLU.
module maxnet_act_update #(
  parameter int unsigned MAX_ITER = 64,
  parameter int unsigned ITER_W   = 8
) (
  input logic                clk,
  input logic                rst,
  maxnet_act_update_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StCheck, StIssue, StWait, StCommit, StFinish
  } state_e;

  localparam logic [ITER_W-1:0] IterMax = ITER_W'(MAX_ITER);

  state_e            state_q, state_d;
  logic [31:0]       a_q [4];
  logic [31:0]       a_d [4];
  logic [31:0]       shadow_q [4];
  logic [31:0]       shadow_d [4];
  logic [1:0]        nrn_sel_q, nrn_sel_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [1:0]        winner_q, winner_d;
  logic              no_winner_q, no_winner_d;

  logic [3:0]        nz;
  logic [2:0]        n_nz;
  logic [1:0]        nz_idx;
  logic [31:0]       init_a [4];

  function automatic logic [31:0] act_fn(input logic [31:0] x);
    logic [31:0] r;
    r = x[31] ? 32'h0 : x;
`ifdef ACT_CLAMP_EN
    if (r > 32'h3F80_0000) r = 32'h3F80_0000;
`endif
    return r;
  endfunction

  assign init_a[0] = bus.init_a1;
  assign init_a[1] = bus.init_a2;
  assign init_a[2] = bus.init_a3;
  assign init_a[3] = bus.init_a4;

  // +0 and -0 both count as zero.
  always_comb begin
    for (int i = 0; i < 4; i++) nz[i] = |a_q[i][30:0];
    n_nz = {2'b00, nz[0]} + {2'b00, nz[1]} + {2'b00, nz[2]} + {2'b00, nz[3]};
    nz_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (nz[i]) nz_idx = 2'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = StCheck;
      StCheck: begin
        if (n_nz <= 3'd1 || iter_cnt_q == IterMax) state_d = StFinish;
        else                                       state_d = StIssue;
      end
      StIssue:  state_d = StWait;
      StWait: begin
        if (bus.plu_done) state_d = (nrn_sel_q == 2'd3) ? StCommit : StIssue;
      end
      StCommit: state_d = StCheck;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.plu_start = (state_q == StIssue);
    bus.busy      = (state_q != StIdle);
    bus.done      = (state_q == StFinish);
  end

  always_comb begin
    a_d         = a_q;
    shadow_d    = shadow_q;
    nrn_sel_d   = nrn_sel_q;
    iter_cnt_d  = iter_cnt_q;
    winner_d    = winner_q;
    no_winner_d = no_winner_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          for (int i = 0; i < 4; i++) a_d[i] = act_fn(init_a[i]);
          iter_cnt_d = '0;
        end
      end
      StCheck: begin
        // A single survivor wins even when the iteration limit is also reached.
        if (n_nz == 3'd1) begin
          winner_d    = nz_idx;
          no_winner_d = 1'b0;
        end else if (n_nz == 3'd0) begin
          no_winner_d = 1'b1;
        end else if (iter_cnt_q == IterMax) begin
          no_winner_d = 1'b1;
          winner_d    = 2'd0;
        end else begin
          nrn_sel_d = 2'd0;
        end
      end
      StWait: begin
        if (bus.plu_done) begin
          shadow_d[nrn_sel_q] = act_fn(bus.plu_out);
          if (nrn_sel_q != 2'd3) nrn_sel_d = nrn_sel_q + 2'd1;
        end
      end
      StCommit: begin
        a_d        = shadow_q;
        iter_cnt_d = iter_cnt_q + ITER_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        a_q[i]      <= 32'h0;
        shadow_q[i] <= 32'h0;
      end
      nrn_sel_q   <= 2'd0;
      iter_cnt_q  <= '0;
      winner_q    <= 2'd0;
      no_winner_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      shadow_q    <= shadow_d;
      nrn_sel_q   <= nrn_sel_d;
      iter_cnt_q  <= iter_cnt_d;
      winner_q    <= winner_d;
      no_winner_q <= no_winner_d;
    end
  end

  assign bus.a1        = a_q[0];
  assign bus.a2        = a_q[1];
  assign bus.a3        = a_q[2];
  assign bus.a4        = a_q[3];
  assign bus.nrn_sel   = nrn_sel_q;
  assign bus.iter_cnt  = iter_cnt_q;
  assign bus.winner    = winner_q;
  assign bus.no_winner = no_winner_q;

endmodule

// File: tb/tb_maxnet_act_update.sv
// Directed bench for maxnet_act_update with a latency-configurable PLU model.
// Define ACT_CLAMP_EN for both RTL and bench to check the clamped build.
module tb_maxnet_act_update;

  localparam int unsigned ITER_W = 8;
`ifdef ACT_CLAMP_EN
  localparam logic [31:0] Res3 = 32'h3F80_0000;
  localparam logic [31:0] Res2 = 32'h3F80_0000;
`else
  localparam logic [31:0] Res3 = 32'h4040_0000;
  localparam logic [31:0] Res2 = 32'h4000_0000;
`endif

  logic clk;
  logic rst;

  maxnet_act_update_if #(.ITER_W(ITER_W)) bus ();

  maxnet_act_update #(.MAX_ITER(3), .ITER_W(ITER_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          lat = 1;
  bit          echo = 1'b0;
  logic [31:0] ret [4];
  int          n_starts = 0;
  logic [7:0]  seq = 8'h0;
  int          stray_req = 0;
  int          stray_ack = 0;
  int          base;
  int          cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] cur_a(input logic [1:0] i);
    case (i)
      2'd0:    return bus.a1;
      2'd1:    return bus.a2;
      2'd2:    return bus.a3;
      default: return bus.a4;
    endcase
  endfunction

  // PLU model: answers each plu_start after lat cycles with a one-cycle plu_done.
  initial begin : plu_model
    bit pend;
    int cd;
    pend = 1'b0;
    cd = 0;
    bus.plu_done = 1'b0;
    bus.plu_out  = 32'h0;
    forever begin
      @(negedge clk);
      bus.plu_done = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (stray_req != stray_ack) begin
          stray_ack    = stray_req;
          bus.plu_out  = 32'h3F80_0000;
          bus.plu_done = 1'b1;
        end
        if (pend) begin
          if (cd <= 1) begin
            bus.plu_out  = echo ? cur_a(bus.nrn_sel) : ret[bus.nrn_sel];
            bus.plu_done = 1'b1;
            pend = 1'b0;
          end else begin
            cd--;
          end
        end
        if (bus.plu_start) begin
          n_starts++;
          seq  = {bus.nrn_sel, seq[7:2]};
          pend = 1'b1;
          cd   = lat;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] i1, i2, i3, i4);
    @(negedge clk);
    bus.init_a1 = i1;
    bus.init_a2 = i2;
    bus.init_a3 = i3;
    bus.init_a4 = i4;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (bus.done !== 1'b1 && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", {31'b0, bus.done}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.start   = 1'b0;
    bus.init_a1 = 32'h0;
    bus.init_a2 = 32'h0;
    bus.init_a3 = 32'h0;
    bus.init_a4 = 32'h0;
    ret = '{32'hBF80_0000, 32'hBF80_0000, 32'h3F00_0000, 32'hBF80_0000};
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_plu_start", {31'b0, bus.plu_start}, 32'd0);
    check("rst_a1", bus.a1, 32'h0);
    check("rst_iter", {24'b0, bus.iter_cnt}, 32'd0);
    check("rst_winner", {30'b0, bus.winner}, 32'd0);
    check("rst_no_winner", {31'b0, bus.no_winner}, 32'd0);
    rst = 1'b0;

    // Single nonzero at entry: done after CHECK, no PLU traffic.
    base = n_starts;
    do_start(32'h3F80_0000, 32'h0, 32'h0, 32'h0);
    wait_done(cyc);
    check("t1_cycles", cyc, 32'd1);
    check("t1_winner", {30'b0, bus.winner}, 32'd0);
    check("t1_no_winner", {31'b0, bus.no_winner}, 32'd0);
    check("t1_iter", {24'b0, bus.iter_cnt}, 32'd0);
    check("t1_starts", n_starts - base, 32'd0);
    check("t1_busy_fin", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    check("t1_done_pulse", {31'b0, bus.done}, 32'd0);
    check("t1_idle", {31'b0, bus.busy}, 32'd0);

    // One iteration, neuron 2 survives.
    lat = 1;
    echo = 1'b0;
    base = n_starts;
    do_start(32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000);
    wait_done(cyc);
    check("t2_cycles", cyc, 32'd11);
    check("t2_winner", {30'b0, bus.winner}, 32'd2);
    check("t2_no_winner", {31'b0, bus.no_winner}, 32'd0);
    check("t2_iter", {24'b0, bus.iter_cnt}, 32'd1);
    check("t2_a1", bus.a1, 32'h0);
    check("t2_a3", bus.a3, 32'h3F00_0000);
    check("t2_a4", bus.a4, 32'h0);
    check("t2_starts", n_starts - base, 32'd4);
    check("t2_nrn_seq", {24'b0, seq}, 32'h0000_00E4);

    // Negatives and -0 ReLU to zero: no survivor.
    base = n_starts;
    do_start(32'h8000_0000, 32'h0, 32'hBF80_0000, 32'h0);
    wait_done(cyc);
    check("t3_cycles", cyc, 32'd1);
    check("t3_no_winner", {31'b0, bus.no_winner}, 32'd1);
    check("t3_iter", {24'b0, bus.iter_cnt}, 32'd0);
    check("t3_a1", bus.a1, 32'h0);
    check("t3_a3", bus.a3, 32'h0);
    check("t3_starts", n_starts - base, 32'd0);

    // Echo model never converges: iteration limit of 3.
    lat = 2;
    echo = 1'b1;
    base = n_starts;
    do_start(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    wait_done(cyc);
    check("t4_cycles", cyc, 32'd43);
    check("t4_no_winner", {31'b0, bus.no_winner}, 32'd1);
    check("t4_winner", {30'b0, bus.winner}, 32'd0);
    check("t4_iter", {24'b0, bus.iter_cnt}, 32'd3);
    check("t4_starts", n_starts - base, 32'd12);
    check("t4_a4", bus.a4, 32'h3F80_0000);
    repeat (2) @(negedge clk);
    check("t4_hold_iter", {24'b0, bus.iter_cnt}, 32'd3);
    check("t4_hold_nw", {31'b0, bus.no_winner}, 32'd1);

    // Values above 1.0 from init and from the PLU.
    lat = 1;
    echo = 1'b0;
    ret = '{32'h4040_0000, 32'h4040_0000, 32'h4040_0000, 32'h4040_0000};
    do_start(32'h4000_0000, 32'h0, 32'h0, 32'h0);
    wait_done(cyc);
    check("t6_init_winner", {30'b0, bus.winner}, 32'd0);
    check("t6_init_a1", bus.a1, Res2);
    do_start(32'h4000_0000, 32'h3F80_0000, 32'h0, 32'h0);
    wait_done(cyc);
    check("t6_cycles", cyc, 32'd31);
    check("t6_no_winner", {31'b0, bus.no_winner}, 32'd1);
    check("t6_a1", bus.a1, Res3);
    check("t6_a3", bus.a3, Res3);

    // Reset while waiting on the PLU in the first iteration.
    lat = 3;
    echo = 1'b1;
    base = n_starts;
    do_start(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    for (int k = 0; k < 100 && (n_starts - base) < 2; k++) @(negedge clk);
    check("t5_reach_wait", n_starts - base, 32'd2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_busy", {31'b0, bus.busy}, 32'd0);
    check("t5_plu_start", {31'b0, bus.plu_start}, 32'd0);
    check("t5_nrn_sel", {30'b0, bus.nrn_sel}, 32'd0);
    check("t5_a1", bus.a1, 32'h0);
    check("t5_iter", {24'b0, bus.iter_cnt}, 32'd0);
    check("t5_no_winner", {31'b0, bus.no_winner}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stray_req++;
    repeat (3) @(negedge clk);
    check("t5_stray_busy", {31'b0, bus.busy}, 32'd0);
    check("t5_stray_a2", bus.a2, 32'h0);

    lat = 1;
    echo = 1'b0;
    ret = '{32'hBF80_0000, 32'hBF80_0000, 32'h3F00_0000, 32'hBF80_0000};
    base = n_starts;
    do_start(32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000);
    wait_done(cyc);
    check("t5_rerun_cycles", cyc, 32'd11);
    check("t5_rerun_winner", {30'b0, bus.winner}, 32'd2);
    check("t5_rerun_iter", {24'b0, bus.iter_cnt}, 32'd1);
    check("t5_rerun_starts", n_starts - base, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
